// File: rtl/hex_scan_pkg.sv
// Shared definitions for the multiplexed hex display driver: blank pattern,
// active-low gfedcba nibble decoder and the per-slot scan state.
package hex_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Slot prescaler and digit index for the scan driver; flags the last cycle
// of each slot (wrap) and of each frame (boundary).
module hex_scan_timer #(
  parameter int unsigned NDIGITS  = 6,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PW       = 16,
  parameter int unsigned IW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] o_pcnt,
  output logic [IW-1:0] o_idx,
  output logic          o_wrap,
  output logic          o_boundary
);

  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  logic [PW-1:0] r_pcnt;
  logic [IW-1:0] r_idx;
  logic          w_wrap;
  logic          w_last_digit;

  assign w_wrap       = (r_pcnt == PCNT_LAST);
  assign w_last_digit = (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (w_wrap) begin
      r_pcnt <= '0;
      r_idx  <= w_last_digit ? '0 : r_idx + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  assign o_pcnt     = r_pcnt;
  assign o_idx      = r_idx;
  assign o_wrap     = w_wrap;
  assign o_boundary = w_wrap && w_last_digit;

endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed hex display driver with blanked dead time and frame-aligned
// double buffering. Optional leading-zero blanking: define HEX_SCAN_LZB_EN.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int unsigned NDIGITS  = 6,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEAD     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  input  logic                   lzb,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     dig_en,
  output logic                   frame_start,
  output logic                   pending
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW:0] DEAD_W = (PW + 1)'(DEAD);
  localparam scan_state_t ST_INIT = (DEAD > 0) ? ST_DEAD : ST_SHOW;

  logic [PW-1:0]        w_pcnt;
  logic [IW-1:0]        w_idx;
  logic                 w_wrap;
  logic                 w_boundary;
  scan_state_t          r_state;
  scan_state_t          w_state_nxt;
  logic [4*NDIGITS-1:0] r_shadow;
  logic [4*NDIGITS-1:0] r_staging;
  logic                 r_pending;
  logic                 r_frame_start;
  logic [6:0]           r_seg;
  logic [NDIGITS-1:0]   r_dig_en;
  logic [6:0]           w_seg_nxt;
  logic [NDIGITS-1:0]   w_dig_nxt;
  logic [3:0]           w_nib;
  logic                 w_blank;

  hex_scan_timer #(
    .NDIGITS  (NDIGITS),
    .PRESCALE (PRESCALE),
    .PW       (PW),
    .IW       (IW)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .o_pcnt     (w_pcnt),
    .o_idx      (w_idx),
    .o_wrap     (w_wrap),
    .o_boundary (w_boundary)
  );

  // r_state tracks the slot phase of the current pcnt, so it is derived
  // from the pcnt value the timer will hold after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (DEAD == 0)
      w_state_nxt = ST_SHOW;
    else if (w_wrap)
      w_state_nxt = ST_DEAD;
    else if (({1'b0, w_pcnt} + 1'b1) < DEAD_W)
      w_state_nxt = ST_DEAD;
    else
      w_state_nxt = ST_SHOW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow      <= '0;
      r_staging     <= '0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if (w_boundary) begin
        if (load)           r_shadow <= value;
        else if (r_pending) r_shadow <= r_staging;
        r_pending <= 1'b0;
      end else if (load) begin
        r_staging <= value;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef HEX_SCAN_LZB_EN
  logic [IW-1:0] w_msn;
  always_comb begin
    w_msn = '0;
    for (int unsigned i = 0; i < NDIGITS; i++)
      if (r_shadow[4*i +: 4] != 4'h0) w_msn = IW'(i);
  end
  assign w_blank = lzb && (w_idx > w_msn);
`else
  logic w_unused_lzb;
  assign w_unused_lzb = lzb;
  assign w_blank      = 1'b0;
`endif

  always_comb begin
    w_nib     = '0;
    w_seg_nxt = SEG_OFF;
    w_dig_nxt = '1;
    for (int unsigned i = 0; i < NDIGITS; i++)
      if (w_idx == IW'(i)) w_nib = r_shadow[4*i +: 4];
    if (r_state == ST_SHOW) begin
      for (int unsigned i = 0; i < NDIGITS; i++)
        w_dig_nxt[i] = (w_idx != IW'(i));
      w_seg_nxt = w_blank ? SEG_OFF : seg_encode(w_nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg    <= SEG_OFF;
      r_dig_en <= '1;
    end else begin
      r_seg    <= w_seg_nxt;
      r_dig_en <= w_dig_nxt;
    end
  end

  assign seg         = r_seg;
  assign dig_en      = r_dig_en;
  assign frame_start = r_frame_start;
  assign pending     = r_pending;

endmodule
